// File: rtl/calc_seq_ctrl_pkg.sv
// Shared constants and FSM encoding for the calc-stage sequencer and the calc stage itself.
package calc_seq_ctrl_pkg;

    localparam int unsigned CALC_CNT_LAST   = 67;
    localparam int unsigned CALC_CNT_W      = 7;
    localparam int unsigned CALC_DATA_W     = 8;
    localparam int unsigned CALC_FIFO_DEPTH = 4;
    localparam int unsigned CALC_FRAMES_W   = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StLatch = 2'd2,
        StCapt  = 2'd3
    } calc_state_e;

endpackage

// File: rtl/calc_seq_ctrl_if.sv
// Operand, calc-stage and result handshake bundle; master = sequencer, slave = environment.
interface calc_seq_ctrl_if
    import calc_seq_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W  = CALC_CNT_W,
    parameter int unsigned DATA_W = CALC_DATA_W
) ();

    logic              src_vld;
    logic              src_rdy;
    logic [CNT_W-1:0]  cnt;
    logic              in_vld;
    logic [DATA_W-1:0] ans_reg;
    logic              res_vld;
    logic              res_rdy;
    logic [DATA_W-1:0] res_data;

    modport master (
        input  src_vld,
        output src_rdy,
        output cnt,
        output in_vld,
        input  ans_reg,
        output res_vld,
        input  res_rdy,
        output res_data
    );

    modport slave (
        output src_vld,
        input  src_rdy,
        input  cnt,
        input  in_vld,
        output ans_reg,
        input  res_vld,
        output res_rdy,
        input  res_data
    );

endinterface

// File: rtl/calc_res_fifo.sv
// Synchronous first-word fall-through result FIFO with count-based full/empty.
module calc_res_fifo
    import calc_seq_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = CALC_DATA_W,
    parameter int unsigned DEPTH  = CALC_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              empty,
    output logic              full
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0]   count_q, count_d;
    logic [DATA_W-1:0] hold_q;
    logic              do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CntW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop frees a slot in the same cycle, so push at full is legal alongside a pop.
    assign do_push = push & (~full | do_pop);

    // When empty, present the last popped head rather than a stale slot.
    assign head = empty ? hold_q : mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                hold_q   <= mem_q[rd_ptr_q];
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/calc_seq_ctrl.sv
// Calc-stage initiator: sequences operand beats into cnt/in_vld, captures ans_reg at frame
// end into a result FIFO and counts completed frames.
module calc_seq_ctrl
    import calc_seq_ctrl_pkg::*;
#(
    parameter int unsigned CNT_LAST   = CALC_CNT_LAST,
    parameter int unsigned CNT_W      = CALC_CNT_W,
    parameter int unsigned DATA_W     = CALC_DATA_W,
    parameter int unsigned FIFO_DEPTH = CALC_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    calc_seq_ctrl_if.master          bus,
    output logic                     busy,
    output logic [CALC_FRAMES_W-1:0] frames
);

    localparam logic [CNT_W-1:0] CntLast  = CNT_W'(CNT_LAST);
    localparam logic [CNT_W-1:0] CntLatch = CNT_W'(CNT_LAST + 1);

    calc_state_e              state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [CALC_FRAMES_W-1:0] frames_q, frames_d;

    logic              src_rdy;
    logic              accept;
    logic              push;
    logic              fifo_empty, fifo_full;
    logic [DATA_W-1:0] fifo_head;

    assign accept = bus.src_vld & src_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            frames_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            frames_q <= frames_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        frames_d = frames_q;
        if (push) begin
            frames_d = frames_q + CALC_FRAMES_W'(1);
        end
        if (abort && state_q != StIdle) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    cnt_d = '0;
                    // Start is dropped, not queued, when it cannot be honoured.
                    if (start && !abort && !fifo_full) begin
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (accept) begin
                        if (cnt_q == CntLast) begin
                            cnt_d   = CntLatch;
                            state_d = StLatch;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                StLatch: begin
                    cnt_d   = '0;
                    state_d = StCapt;
                end
                StCapt: begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end
                default: begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_comb begin
        src_rdy = 1'b0;
        push    = 1'b0;
        busy    = (state_q != StIdle);
        unique case (state_q)
            StRun:   src_rdy = ~abort;
            StCapt:  push    = ~abort;
            default: ;
        endcase
    end

    calc_res_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_res_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (bus.ans_reg),
        .pop       (bus.res_rdy),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign bus.src_rdy  = src_rdy;
    assign bus.in_vld   = accept;
    assign bus.cnt      = cnt_q;
    assign bus.res_vld  = ~fifo_empty;
    assign bus.res_data = fifo_head;
    assign frames       = frames_q;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Directed bench for calc_seq_ctrl: full, gappy, FIFO-full, abort, push+pop and async reset.
module tb_calc_seq_ctrl;
    import calc_seq_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        busy;
    logic [15:0] frames;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    calc_seq_ctrl_if #(.CNT_W(7), .DATA_W(8)) bus ();

    calc_seq_ctrl dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .abort  (abort),
        .bus    (bus),
        .busy   (busy),
        .frames (frames)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // All tasks begin and end just after a falling edge.
    task automatic start_frame();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check_eq("run_busy", 32'(busy), 32'd1);
        check_eq("run_cnt0", 32'(bus.cnt), 32'd0);
    endtask

    task automatic feed_beats(input int n, input bit gappy, output int cycles);
        int beat = 0;
        int cyc  = 0;
        while (beat < n && cyc < 1000) begin
            bus.src_vld = gappy ? (cyc % 2 == 1) : 1'b1;
            #1;
            check_eq("beat_cnt", 32'(bus.cnt), 32'(beat));
            check_eq("beat_in_vld", 32'(bus.in_vld), 32'(bus.src_vld));
            if (bus.src_vld) beat++;
            cyc++;
            @(negedge clk);
        end
        bus.src_vld = 1'b0;
        check_eq("feed_done", 32'(beat), 32'(n));
        cycles = cyc;
    endtask

    task automatic finish_frame(input bit pop_in_capt, input logic capt_vld,
                                input logic [7:0] capt_head, input logic [15:0] exp_frames,
                                input logic [7:0] exp_head);
        // Latch slot: a beat offered here must not be accepted.
        bus.src_vld = 1'b1;
        #1;
        check_eq("latch_cnt", 32'(bus.cnt), 32'd68);
        check_eq("latch_in_vld", 32'(bus.in_vld), 32'd0);
        check_eq("latch_src_rdy", 32'(bus.src_rdy), 32'd0);
        @(negedge clk);
        bus.src_vld = 1'b0;
        bus.res_rdy = pop_in_capt;
        #1;
        check_eq("capt_cnt", 32'(bus.cnt), 32'd0);
        check_eq("capt_busy", 32'(busy), 32'd1);
        check_eq("capt_res_vld", 32'(bus.res_vld), 32'(capt_vld));
        if (capt_vld) check_eq("capt_head", 32'(bus.res_data), 32'(capt_head));
        @(negedge clk);
        bus.res_rdy = 1'b0;
        #1;
        check_eq("done_busy", 32'(busy), 32'd0);
        check_eq("done_frames", 32'(frames), 32'(exp_frames));
        check_eq("done_res_vld", 32'(bus.res_vld), 32'd1);
        check_eq("done_res_data", 32'(bus.res_data), 32'(exp_head));
    endtask

    task automatic pop_one(input logic exp_vld_after, input logic [7:0] exp_data_after);
        bus.res_rdy = 1'b1;
        @(negedge clk);
        bus.res_rdy = 1'b0;
        #1;
        check_eq("pop_res_vld", 32'(bus.res_vld), 32'(exp_vld_after));
        check_eq("pop_res_data", 32'(bus.res_data), 32'(exp_data_after));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cycles;
        rst_n       = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        bus.src_vld = 1'b0;
        bus.ans_reg = 8'h00;
        bus.res_rdy = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_cnt", 32'(bus.cnt), 32'd0);
        check_eq("rst_src_rdy", 32'(bus.src_rdy), 32'd0);
        check_eq("rst_in_vld", 32'(bus.in_vld), 32'd0);
        check_eq("rst_res_vld", 32'(bus.res_vld), 32'd0);
        check_eq("rst_res_data", 32'(bus.res_data), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_frames", 32'(frames), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: back-to-back frame
        bus.ans_reg = 8'h5A;
        start_frame();
        feed_beats(68, 1'b0, cycles);
        check_eq("b2b_cycles", 32'(cycles), 32'd68);
        finish_frame(1'b0, 1'b0, 8'h00, 16'd1, 8'h5A);
        pop_one(1'b0, 8'h5A);

        // 2: alternating gaps
        start_frame();
        feed_beats(68, 1'b1, cycles);
        check_eq("gap_cycles", 32'(cycles), 32'd136);
        finish_frame(1'b0, 1'b0, 8'h00, 16'd2, 8'h5A);
        pop_one(1'b0, 8'h5A);

        // 3: fill FIFO, dropped start, ordered drain
        for (int f = 1; f <= 4; f++) begin
            bus.ans_reg = 8'(f);
            start_frame();
            feed_beats(68, 1'b0, cycles);
            finish_frame(1'b0, f > 1, 8'h01, 16'(2 + f), 8'h01);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check_eq("full_start_busy", 32'(busy), 32'd0);
        check_eq("full_start_rdy", 32'(bus.src_rdy), 32'd0);
        @(negedge clk);
        #1;
        check_eq("full_still_idle", 32'(busy), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            check_eq("drain_vld", 32'(bus.res_vld), 32'd1);
            check_eq("drain_data", 32'(bus.res_data), 32'(k));
            bus.res_rdy = 1'b1;
            @(negedge clk);
            bus.res_rdy = 1'b0;
            #1;
        end
        check_eq("drained_vld", 32'(bus.res_vld), 32'd0);
        check_eq("drained_hold", 32'(bus.res_data), 32'd4);

        // 4: abort at cnt=40 with a beat offered
        bus.ans_reg = 8'hEE;
        start_frame();
        feed_beats(40, 1'b0, cycles);
        bus.src_vld = 1'b1;
        abort       = 1'b1;
        #1;
        check_eq("abort_cnt", 32'(bus.cnt), 32'd40);
        check_eq("abort_in_vld", 32'(bus.in_vld), 32'd0);
        check_eq("abort_src_rdy", 32'(bus.src_rdy), 32'd0);
        @(negedge clk);
        abort       = 1'b0;
        bus.src_vld = 1'b0;
        #1;
        check_eq("aborted_busy", 32'(busy), 32'd0);
        check_eq("aborted_cnt", 32'(bus.cnt), 32'd0);
        check_eq("aborted_frames", 32'(frames), 32'd6);
        check_eq("aborted_res_vld", 32'(bus.res_vld), 32'd0);
        @(negedge clk);
        #1;
        check_eq("aborted_no_push", 32'(bus.res_vld), 32'd0);
        bus.ans_reg = 8'h77;
        start_frame();
        feed_beats(68, 1'b0, cycles);
        finish_frame(1'b0, 1'b0, 8'h00, 16'd7, 8'h77);

        // 5: push and pop in the CAPT cycle with one entry held
        bus.ans_reg = 8'h33;
        start_frame();
        feed_beats(68, 1'b0, cycles);
        finish_frame(1'b1, 1'b1, 8'h77, 16'd8, 8'h33);
        pop_one(1'b0, 8'h33);

        // 6: asynchronous reset mid-frame
        start_frame();
        feed_beats(20, 1'b0, cycles);
        bus.src_vld = 1'b1;
        #1;
        check_eq("pre_rst_cnt", 32'(bus.cnt), 32'd20);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("arst_cnt", 32'(bus.cnt), 32'd0);
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_src_rdy", 32'(bus.src_rdy), 32'd0);
        check_eq("arst_in_vld", 32'(bus.in_vld), 32'd0);
        check_eq("arst_res_vld", 32'(bus.res_vld), 32'd0);
        check_eq("arst_res_data", 32'(bus.res_data), 32'd0);
        check_eq("arst_frames", 32'(frames), 32'd0);
        @(negedge clk);
        bus.src_vld = 1'b0;
        rst_n       = 1'b1;
        @(negedge clk);
        #1;
        check_eq("post_rst_busy", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
